// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV: one quotient bit per clock, quotient to LO, remainder to HI.
// Defining DIV_UNSIGNED_EN adds the is_unsigned input, which selects DIVU.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
`ifdef DIV_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   // state | meaning
   // IDLE  | waiting for start; divide-by-zero is flagged from here
   // RUN   | one restoring shift-subtract step per clock
   // FIX   | apply result signs, publish HI/LO, pulse done
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic             neg_q;
   logic             neg_r;

   logic             uns;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;

`ifdef DIV_UNSIGNED_EN
   assign uns = is_unsigned;
`else
   assign uns = 1'b0;
`endif

   // |most-negative| wraps back to itself, which is exactly 2^(WIDTH-1) read as unsigned
   assign a_abs = (!uns && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
   assign b_abs = (!uns && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;

   // One extra bit beyond the shifted remainder keeps the borrow unambiguous
   // when an unsigned divisor has its MSB set.
   assign rem_sh = {rem, dvd[WIDTH-1]};
   assign diff   = {1'b0, rem_sh} - {2'b00, dvs};

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (b_in == '0) begin
                     div_zero <= 1'b1;
                  end else begin
                     dvd   <= a_abs;
                     dvs   <= b_abs;
                     rem   <= '0;
                     neg_q <= !uns && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                     neg_r <= !uns && a_in[WIDTH-1];
                     cnt   <= CNT_W'(WIDTH - 1);
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (diff[WIDTH+1]) begin
                  rem <= rem_sh[WIDTH-1:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b0};
               end else begin
                  rem <= diff[WIDTH-1:0];
                  dvd <= {dvd[WIDTH-2:0], 1'b1};
               end
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIX: begin
               lo_out <= neg_q ? (~dvd + 1'b1) : dvd;
               hi_out <= neg_r ? (~rem + 1'b1) : rem;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
